serial_byte_sender: RTL and testbench
=====================================

SERIAL_BYTE_SENDER -- requirements
Module: serial_byte_sender

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-low.
REQ-002 Parameter HIGH_CYCLES SHALL be: default 10; number of cycles write_out is high per bit.
REQ-003 Parameter LOW_CYCLES SHALL be: default 10; number of cycles write_out is low after each bit.
REQ-004 Parameter DEPTH SHALL be: default 4; byte FIFO depth, power of two, at least 2.
REQ-005 Port clock1M SHALL be: input, 1 bit, system clock.
REQ-006 Port reset SHALL be: input, 1 bit, synchronous active-low reset.
REQ-007 Port byte_in SHALL be: input, 8 bits, byte to transmit.
REQ-008 Port byte_valid SHALL be: input, 1 bit, byte_in is valid.
REQ-009 Port byte_ready SHALL be: output, 1 bit, FIFO can accept a byte.
REQ-010 Port data_out SHALL be: output, 1 bit, serial data bit, MSB first.
REQ-011 Port write_out SHALL be: output, 1 bit, bit strobe; data_out is valid while it is high.
REQ-012 Port busy SHALL be: output, 1 bit, serializer is not in IDLE.
REQ-013 Port count_out SHALL be: output, clog2(DEPTH)+1 bits, number of FIFO entries.

Function
REQ-014 A byte SHALL be enqueued on a rising edge where byte_valid and byte_ready are both 1; byte_ready SHALL equal (count_out != DEPTH), combinationally.
REQ-015 The FSM SHALL have three states, IDLE, HIGH and LOW, plus a 3-bit bit index and a cycle counter sized for max(HIGH_CYCLES, LOW_CYCLES).
REQ-016 When in IDLE with the FIFO non-empty, the FSM SHALL pop the head on the next edge, load the shift register, set bit index 7 and enter HIGH.
REQ-017 In HIGH, write_out SHALL be 1 and data_out SHALL be the current bit, for exactly HIGH_CYCLES cycles; the FSM SHALL then enter LOW.
REQ-018 In LOW, write_out SHALL be 0 and data_out SHALL hold the current bit, for exactly LOW_CYCLES cycles.
REQ-019 At the end of LOW with bit index greater than 0, the FSM SHALL decrement the index and re-enter HIGH.
REQ-020 At the end of LOW with bit index 0, the FSM SHALL pop the next byte and enter HIGH on the same edge if the FIFO is non-empty; otherwise it SHALL enter IDLE.
REQ-021 Back-to-back bytes SHALL have no gap: each byte SHALL take 8*(HIGH_CYCLES+LOW_CYCLES) cycles.
REQ-022 Latency SHALL be as follows: a byte pushed at edge N into an empty FIFO while in IDLE raises write_out after edge N+1.
REQ-023 On a simultaneous push and pop, count_out SHALL be unchanged and FIFO order SHALL be preserved.
REQ-024 When the FIFO is full, byte_ready SHALL be 0 and byte_valid SHALL be ignored; a pop on that edge SHALL make byte_ready 1 on the following cycle.
REQ-025 In IDLE, data_out SHALL be 0 and write_out SHALL be 0.
REQ-026 FIFO pointers SHALL wrap modulo DEPTH.

Reset
REQ-027 While reset=0 at a clock edge, the block SHALL clear the FIFO (count_out=0), force the FSM to IDLE, and set data_out=0, write_out=0, busy=0 and byte_ready=1.
REQ-028 Reset asserted mid-byte SHALL abort the transfer immediately; no partial bit SHALL be emitted after release.

Structure
REQ-029 A shared package sender_pkg SHALL hold the FSM state enum (IDLE, HIGH, LOW) and the default HIGH_CYCLES, LOW_CYCLES and DEPTH constants.
REQ-030 The FIFO SHALL be a sub-module byte_fifo, with parameter DEPTH, push/pop/full/empty/count ports and synchronous active-low reset.

Verification
REQ-031 The bench SHALL check: push 8'hA5 once -> write_out pulses 8 times, each 10 high + 10 low cycles; data_out during the pulses is 1,0,1,0,0,1,0,1; busy then falls.
REQ-032 The bench SHALL check: push 8'hA5 then 8'h3C back-to-back -> 16 pulses with no idle gap, total 320 cycles, and bits 3C are emitted after A5.
REQ-033 The bench SHALL check: hold byte_valid for 6 bytes while one is transmitting -> byte_ready falls when count_out=4, extra bytes are not lost (held), and all 6 bytes are emitted in order.
REQ-034 The bench SHALL check: assert reset during bit 3 of 8'hFF -> the next cycle has write_out=0, data_out=0, count_out=0; after release, output stays idle until a new push.
REQ-035 The bench SHALL check: with the FIFO at count 2, push and pop on the same edge -> count_out stays 2 and order is preserved.
REQ-036 The bench SHALL check: with HIGH_CYCLES=2 and LOW_CYCLES=3, push 8'h80 -> the first pulse is 2 cycles high with data_out=1, then 7 pulses with data_out=0, for a total of 40 cycles.

Source files
------------

// File: rtl/sender_pkg.sv
// sender_pkg
//   Shared types and default constants for the serial byte sender slice.
//   Contents:
//     sender_state_t      - serializer FSM state (IDLE, HIGH, LOW)
//     DEFAULT_HIGH_CYCLES - default strobe-high duration per bit, in clocks
//     DEFAULT_LOW_CYCLES  - default strobe-low duration after each bit
//     DEFAULT_DEPTH       - default byte FIFO depth (power of two, >= 2)
//     max_int()           - constant helper used to size the cycle counter
package sender_pkg;

  localparam int DEFAULT_HIGH_CYCLES = 10;
  localparam int DEFAULT_LOW_CYCLES  = 10;
  localparam int DEFAULT_DEPTH       = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } sender_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// byte_fifo
//   Small synchronous byte FIFO with a combinational head read.
//   Parameters:
//     DEPTH     - number of entries; must be a power of two and at least 2
//   Ports:
//     clock1M   - system clock
//     reset     - synchronous active-low reset; empties the FIFO
//     push      - write push_data this edge (ignored while full)
//     push_data - byte to store
//     pop       - drop the head entry this edge (ignored while empty)
//     pop_data  - current head entry, valid while not empty
//     full      - count == DEPTH
//     empty     - count == 0
//     count     - number of stored entries, 0..DEPTH
module byte_fifo
  import sender_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                     clock1M,
  input  logic                     reset,
  input  logic                     push,
  input  logic [7:0]               push_data,
  input  logic                     pop,
  output logic [7:0]               pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == FULL_COUNT);
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Storage is not reset; only the pointers and count define what is valid.
  always_ff @(posedge clock1M) begin
    if (reset && do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers are exactly log2(DEPTH) bits wide, so they wrap modulo DEPTH
  // without any compare. A simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clock1M) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/serial_byte_sender.sv
// serial_byte_sender
//   Queues bytes in a FIFO and shifts each one out MSB first. Every bit is
//   presented on data_out for HIGH_CYCLES clocks with write_out high, then
//   held for LOW_CYCLES clocks with write_out low. Consecutive queued bytes
//   follow each other with no idle gap.
//   Parameters:
//     HIGH_CYCLES - clocks write_out is high per bit (>= 1)
//     LOW_CYCLES  - clocks write_out is low after each bit (>= 1)
//     DEPTH       - byte FIFO depth (power of two, >= 2)
//   Ports:
//     clock1M    - system clock
//     reset      - synchronous active-low reset; aborts any transfer
//     byte_in    - byte to queue
//     byte_valid - byte_in is valid; accepted on an edge where byte_ready=1
//     byte_ready - FIFO has room (count_out != DEPTH)
//     data_out   - serial data bit, 0 while idle
//     write_out  - bit strobe; data_out is valid while it is high
//     busy       - serializer is not idle
//     count_out  - number of queued bytes
module serial_byte_sender
  import sender_pkg::*;
#(
  parameter int HIGH_CYCLES = DEFAULT_HIGH_CYCLES,
  parameter int LOW_CYCLES  = DEFAULT_LOW_CYCLES,
  parameter int DEPTH       = DEFAULT_DEPTH
) (
  input  logic                   clock1M,
  input  logic                   reset,
  input  logic [7:0]             byte_in,
  input  logic                   byte_valid,
  output logic                   byte_ready,
  output logic                   data_out,
  output logic                   write_out,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] count_out
);

  // The cycle counter only has to reach max(HIGH_CYCLES, LOW_CYCLES) - 1.
  localparam int MAX_CYCLES = max_int(HIGH_CYCLES, LOW_CYCLES);
  localparam int CYC_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CYC_W-1:0] HIGH_LAST = CYC_W'(HIGH_CYCLES - 1);
  localparam logic [CYC_W-1:0] LOW_LAST  = CYC_W'(LOW_CYCLES - 1);

  sender_state_t    state;
  sender_state_t    state_nxt;
  logic [CYC_W-1:0] cycle_cnt;
  logic [CYC_W-1:0] cycle_cnt_nxt;
  logic [2:0]       bit_idx;
  logic [2:0]       bit_idx_nxt;
  logic [7:0]       shift_reg;
  logic [7:0]       shift_reg_nxt;

  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [7:0]       fifo_head;

  byte_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock1M   (clock1M),
    .reset     (reset),
    .push      (byte_valid),
    .push_data (byte_in),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (count_out)
  );

  assign byte_ready = !fifo_full;

  // Outputs decode straight from registered state, so a reset edge takes
  // effect on the very next cycle with no partial bit left on the wire.
  assign busy      = (state != IDLE);
  assign write_out = (state == HIGH);
  assign data_out  = (state == IDLE) ? 1'b0 : shift_reg[bit_idx];

  always_ff @(posedge clock1M) begin
    if (!reset) begin
      state     <= IDLE;
      cycle_cnt <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
    end else begin
      state     <= state_nxt;
      cycle_cnt <= cycle_cnt_nxt;
      bit_idx   <= bit_idx_nxt;
      shift_reg <= shift_reg_nxt;
    end
  end

  // Next-state logic. A byte is loaded either from IDLE or directly at the
  // end of the last bit's LOW phase, which is what removes the gap between
  // back-to-back bytes.
  always_comb begin
    state_nxt     = state;
    cycle_cnt_nxt = cycle_cnt;
    bit_idx_nxt   = bit_idx;
    shift_reg_nxt = shift_reg;
    fifo_pop      = 1'b0;

    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop      = 1'b1;
          shift_reg_nxt = fifo_head;
          bit_idx_nxt   = 3'd7;
          cycle_cnt_nxt = '0;
          state_nxt     = HIGH;
        end
      end

      HIGH: begin
        if (cycle_cnt == HIGH_LAST) begin
          cycle_cnt_nxt = '0;
          state_nxt     = LOW;
        end else begin
          cycle_cnt_nxt = cycle_cnt + CYC_W'(1);
        end
      end

      LOW: begin
        if (cycle_cnt == LOW_LAST) begin
          cycle_cnt_nxt = '0;
          if (bit_idx != 3'd0) begin
            bit_idx_nxt = bit_idx - 3'd1;
            state_nxt   = HIGH;
          end else if (!fifo_empty) begin
            fifo_pop      = 1'b1;
            shift_reg_nxt = fifo_head;
            bit_idx_nxt   = 3'd7;
            state_nxt     = HIGH;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          cycle_cnt_nxt = cycle_cnt + CYC_W'(1);
        end
      end

      default: begin
        state_nxt     = IDLE;
        cycle_cnt_nxt = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_serial_byte_sender.sv
// tb_serial_byte_sender
//   Directed bench for serial_byte_sender. One instance uses the default
//   timing (10/10, depth 4), a second uses HIGH_CYCLES=2, LOW_CYCLES=3.
//   Inputs change and outputs are sampled on the falling clock edge.
module tb_serial_byte_sender;

  logic       clock1M;
  logic       reset;

  logic [7:0] byte_in;
  logic       byte_valid;
  logic       byte_ready;
  logic       data_out;
  logic       write_out;
  logic       busy;
  logic [2:0] count_out;

  logic [7:0] f_byte_in;
  logic       f_byte_valid;
  logic       f_byte_ready;
  logic       f_data_out;
  logic       f_write_out;
  logic       f_busy;
  logic [2:0] f_count_out;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  serial_byte_sender dut (
    .clock1M    (clock1M),
    .reset      (reset),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .data_out   (data_out),
    .write_out  (write_out),
    .busy       (busy),
    .count_out  (count_out)
  );

  serial_byte_sender #(
    .HIGH_CYCLES (2),
    .LOW_CYCLES  (3),
    .DEPTH       (4)
  ) dut_fast (
    .clock1M    (clock1M),
    .reset      (reset),
    .byte_in    (f_byte_in),
    .byte_valid (f_byte_valid),
    .byte_ready (f_byte_ready),
    .data_out   (f_data_out),
    .write_out  (f_write_out),
    .busy       (f_busy),
    .count_out  (f_count_out)
  );

  initial clock1M = 1'b0;
  always #5 clock1M = ~clock1M;

  always @(posedge clock1M) cyc <= cyc + 1;

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic sample_write(input bit fast);
    return fast ? f_write_out : write_out;
  endfunction

  function automatic logic sample_data(input bit fast);
    return fast ? f_data_out : data_out;
  endfunction

  function automatic logic sample_busy(input bit fast);
    return fast ? f_busy : busy;
  endfunction

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus(input logic [7:0] value, input logic valid);
    byte_in    = value;
    byte_valid = valid;
  endtask

  // Waits (bounded) until the selected DUT raises write_out.
  task automatic wait_write_high(input bit fast, input int limit, input string tag);
    int n = 0;
    while (!sample_write(fast) && n < limit) begin
      @(negedge clock1M);
      n++;
    end
    check_output(tag, 32'(sample_write(fast)), 32'd1);
  endtask

  // Starts on the first write_out-high sample of a byte; measures every
  // high and low run, checks the data bit is held across both, and
  // rebuilds the byte MSB first. Returns on the sample after the last LOW.
  task automatic receive_byte(input bit fast, input logic [7:0] expected,
                              input int hc, input int lc, input string tag);
    logic [7:0] got;
    logic       bit_val;
    int         hi_len;
    int         lo_len;
    int         unstable;
    got      = '0;
    unstable = 0;
    for (int i = 7; i >= 0; i--) begin
      hi_len  = 0;
      lo_len  = 0;
      bit_val = sample_data(fast);
      while (sample_write(fast) && hi_len < hc + 4) begin
        if (sample_data(fast) !== bit_val) unstable++;
        hi_len++;
        @(negedge clock1M);
      end
      while (!sample_write(fast) && sample_busy(fast) && lo_len < lc + 4) begin
        if (sample_data(fast) !== bit_val) unstable++;
        lo_len++;
        @(negedge clock1M);
      end
      got[i] = bit_val;
      check_output($sformatf("%s hi_len bit%0d", tag, i), 32'(hi_len), 32'(hc));
      check_output($sformatf("%s lo_len bit%0d", tag, i), 32'(lo_len), 32'(lc));
    end
    check_output({tag, " data_hold"}, 32'(unstable), 32'd0);
    check_output({tag, " byte"}, 32'(got), 32'(expected));
  endtask

  logic [7:0] t3_bytes [6];
  logic [7:0] t4_bytes [4];

  initial begin
    int start_cyc;
    int hits;

    t3_bytes = '{8'h01, 8'h80, 8'hC3, 8'h5A, 8'hF0, 8'h0F};
    t4_bytes = '{8'h96, 8'h4B, 8'hE1, 8'h2D};

    // Reset state of both instances.
    reset        = 1'b0;
    f_byte_in    = 8'h00;
    f_byte_valid = 1'b0;
    apply_stimulus(8'h00, 1'b0);
    repeat (3) @(negedge clock1M);
    check_output("reset count_out", 32'(count_out), 32'd0);
    check_output("reset byte_ready", 32'(byte_ready), 32'd1);
    check_output("reset write_out", 32'(write_out), 32'd0);
    check_output("reset data_out", 32'(data_out), 32'd0);
    check_output("reset busy", 32'(busy), 32'd0);
    check_output("reset fast busy", 32'(f_busy), 32'd0);
    reset = 1'b1;

    // Single byte A5 with the push-to-strobe latency.
    $display("[TB] single byte A5");
    @(negedge clock1M);
    apply_stimulus(8'hA5, 1'b1);
    @(negedge clock1M);
    apply_stimulus(8'h00, 1'b0);
    check_output("T1 count after push", 32'(count_out), 32'd1);
    check_output("T1 write_out after push", 32'(write_out), 32'd0);
    @(negedge clock1M);
    check_output("T1 latency write_out", 32'(write_out), 32'd1);
    check_output("T1 count after pop", 32'(count_out), 32'd0);
    check_output("T1 busy", 32'(busy), 32'd1);
    receive_byte(1'b0, 8'hA5, 10, 10, "T1 A5");
    check_output("T1 busy end", 32'(busy), 32'd0);
    check_output("T1 idle data_out", 32'(data_out), 32'd0);
    check_output("T1 idle write_out", 32'(write_out), 32'd0);

    // Back-to-back A5 then 3C: 320 cycles, no gap.
    $display("[TB] back-to-back A5 3C");
    @(negedge clock1M);
    apply_stimulus(8'hA5, 1'b1);
    @(negedge clock1M);
    apply_stimulus(8'h3C, 1'b1);
    @(negedge clock1M);
    apply_stimulus(8'h00, 1'b0);
    start_cyc = cyc;
    check_output("T2 start write_out", 32'(write_out), 32'd1);
    receive_byte(1'b0, 8'hA5, 10, 10, "T2 A5");
    receive_byte(1'b0, 8'h3C, 10, 10, "T2 3C");
    check_output("T2 total cycles", 32'(cyc - start_cyc), 32'd320);
    check_output("T2 busy end", 32'(busy), 32'd0);

    // Six bytes offered while one transmits: FIFO fills, last byte waits.
    $display("[TB] fill FIFO with six bytes");
    @(negedge clock1M);
    fork
      begin
        int  k;
        int  j;
        logic rdy;
        k = 0;
        j = 0;
        apply_stimulus(t3_bytes[0], 1'b1);
        while (k < 6 && j < 2000) begin
          rdy = byte_ready;
          @(negedge clock1M);
          j++;
          if (rdy) k++;
          if (k < 6) apply_stimulus(t3_bytes[k], 1'b1);
          else       apply_stimulus(8'h00, 1'b0);
          if (j == 5) begin
            check_output("T3 full count", 32'(count_out), 32'd4);
            check_output("T3 full ready", 32'(byte_ready), 32'd0);
          end
          if (j == 6) begin
            check_output("T3 held count", 32'(count_out), 32'd4);
            check_output("T3 held ready", 32'(byte_ready), 32'd0);
          end
        end
        check_output("T3 all accepted", 32'(k), 32'd6);
      end
      begin
        wait_write_high(1'b0, 50, "T3 start");
        for (int b = 0; b < 6; b++) begin
          receive_byte(1'b0, t3_bytes[b], 10, 10, $sformatf("T3 byte%0d", b));
        end
      end
    join
    check_output("T3 drained", 32'(count_out), 32'd0);

    // Push and pop on the same edge with two bytes queued.
    $display("[TB] simultaneous push and pop");
    @(negedge clock1M);
    fork
      begin
        int j;
        apply_stimulus(t4_bytes[0], 1'b1);
        @(negedge clock1M);
        apply_stimulus(t4_bytes[1], 1'b1);
        @(negedge clock1M);
        apply_stimulus(t4_bytes[2], 1'b1);
        @(negedge clock1M);
        apply_stimulus(8'h00, 1'b0);
        check_output("T4 count two", 32'(count_out), 32'd2);
        j = 3;
        while (j < 161) begin
          @(negedge clock1M);
          j++;
        end
        check_output("T4 count before", 32'(count_out), 32'd2);
        apply_stimulus(t4_bytes[3], 1'b1);
        @(negedge clock1M);
        apply_stimulus(8'h00, 1'b0);
        check_output("T4 count unchanged", 32'(count_out), 32'd2);
      end
      begin
        wait_write_high(1'b0, 50, "T4 start");
        for (int b = 0; b < 4; b++) begin
          receive_byte(1'b0, t4_bytes[b], 10, 10, $sformatf("T4 byte%0d", b));
        end
      end
    join

    // Reset in the middle of bit 3 of FF with another byte queued.
    $display("[TB] reset mid-byte");
    @(negedge clock1M);
    apply_stimulus(8'hFF, 1'b1);
    @(negedge clock1M);
    apply_stimulus(8'h77, 1'b1);
    @(negedge clock1M);
    apply_stimulus(8'h00, 1'b0);
    repeat (85) @(negedge clock1M);
    check_output("T5 pre write_out", 32'(write_out), 32'd1);
    check_output("T5 pre data_out", 32'(data_out), 32'd1);
    check_output("T5 pre count", 32'(count_out), 32'd1);
    reset = 1'b0;
    @(negedge clock1M);
    check_output("T5 rst write_out", 32'(write_out), 32'd0);
    check_output("T5 rst data_out", 32'(data_out), 32'd0);
    check_output("T5 rst count", 32'(count_out), 32'd0);
    check_output("T5 rst busy", 32'(busy), 32'd0);
    check_output("T5 rst byte_ready", 32'(byte_ready), 32'd1);
    reset = 1'b1;
    hits = 0;
    repeat (30) begin
      @(negedge clock1M);
      if (write_out || busy || data_out) hits++;
    end
    check_output("T5 idle after release", 32'(hits), 32'd0);
    apply_stimulus(8'h5A, 1'b1);
    @(negedge clock1M);
    apply_stimulus(8'h00, 1'b0);
    wait_write_high(1'b0, 5, "T5 restart");
    receive_byte(1'b0, 8'h5A, 10, 10, "T5 5A");
    check_output("T5 busy end", 32'(busy), 32'd0);

    // Short timing instance: 2 high + 3 low per bit, 40 cycles per byte.
    $display("[TB] fast timing 80");
    @(negedge clock1M);
    f_byte_in    = 8'h80;
    f_byte_valid = 1'b1;
    @(negedge clock1M);
    f_byte_valid = 1'b0;
    @(negedge clock1M);
    start_cyc = cyc;
    check_output("T6 latency write_out", 32'(f_write_out), 32'd1);
    check_output("T6 first data_out", 32'(f_data_out), 32'd1);
    receive_byte(1'b1, 8'h80, 2, 3, "T6 80");
    check_output("T6 total cycles", 32'(cyc - start_cyc), 32'd40);
    check_output("T6 busy end", 32'(f_busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
